// File: rtl/run_monitor.sv
// Run-length monitor: measures consecutive high samples of Y and queues each
// completed run length into a small show-ahead FIFO for a downstream consumer.
// Optional feature: define RUN_MONITOR_OVF_EN to add a sticky 'ovf' output
// that flags any run length dropped because the FIFO was full.
module run_monitor #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LEN_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     Y,
  output logic [LEN_W-1:0]         run_len,
  output logic                     run_valid,
  input  logic                     run_ready,
  output logic [$clog2(DEPTH):0]   fifo_cnt,
`ifdef RUN_MONITOR_OVF_EN
  output logic                     ovf,
`endif
  output logic                     busy
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                  state_q, state_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [LEN_W-1:0]        mem_q [DEPTH];
  logic [LEN_W-1:0]        mem_d [DEPTH];
  logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    push, pop, full, wr_en;

  // Run detector: count consecutive highs, emit a push when the run ends.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    push    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (Y) begin
          state_d = StRun;
          len_d   = LEN_W'(1);
        end
      end
      StRun: begin
        if (Y) begin
          // Saturate instead of wrapping on very long runs.
          if (len_q != '1) len_d = len_q + 1'b1;
        end else begin
          push    = 1'b1;
          state_d = StIdle;
          len_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FIFO bookkeeping; a pop on the same edge frees room for a push when full.
  always_comb begin
    pop      = run_valid && run_ready;
    full     = (cnt_q == CntW'(DEPTH));
    wr_en    = push && (!full || pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = len_q;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // State, counter and FIFO registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      len_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end

  // Show-ahead outputs; head is forced to zero while empty.
  always_comb begin
    run_valid = (cnt_q != '0);
    run_len   = run_valid ? mem_q[rd_ptr_q] : '0;
    fifo_cnt  = cnt_q;
    busy      = (state_q == StRun);
  end

`ifdef RUN_MONITOR_OVF_EN
  logic ovf_q, ovf_d;

  // Sticky drop flag, cleared only by reset.
  always_comb begin
    ovf_d = ovf_q | (push & ~wr_en);
    ovf   = ovf_q;
  end

  // Drop flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end
`endif

endmodule

// File: tb/tb_run_monitor.sv
// Self-checking bench for run_monitor (DEPTH=4, LEN_W=8): per-cycle table,
// queue-based scoreboard of expected run lengths, and directed corner cases.
module tb_run_monitor;

  localparam int Depth  = 4;
  localparam int LenMax = 255;

  logic       clk, rst, Y, run_ready, run_valid, busy;
  logic [7:0] run_len;
  logic [2:0] fifo_cnt;
`ifdef RUN_MONITOR_OVF_EN
  logic       ovf;
`endif

  run_monitor #(.DEPTH(4), .LEN_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .Y         (Y),
    .run_len   (run_len),
    .run_valid (run_valid),
    .run_ready (run_ready),
    .fifo_cnt  (fifo_cnt),
`ifdef RUN_MONITOR_OVF_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  logic [7:0] sb[$];
  logic [7:0] popped[$];
  bit         m_busy = 1'b0;
  int         m_len  = 0;
  bit         m_ovf  = 1'b0;

  typedef struct {
    logic       y;
    logic       ready;
    logic       valid;
    logic [7:0] len;
    logic [2:0] cnt;
    logic       bsy;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock: update the model from the driven inputs, then compare.
  task automatic step();
    int sz;
    bit pop_e;
    sz    = sb.size();
    pop_e = (sz != 0) && run_ready;
    if (pop_e) begin
      check("pop_head", run_len, sb[0]);
      popped.push_back(run_len);
      void'(sb.pop_front());
    end
    if (m_busy && !Y) begin
      if (sz < Depth || pop_e) sb.push_back(8'(m_len));
      else m_ovf = 1'b1;
      m_busy = 1'b0;
    end else if (m_busy && Y) begin
      if (m_len != LenMax) m_len++;
    end else if (Y) begin
      m_busy = 1'b1;
      m_len  = 1;
    end
    @(posedge clk);
    #1;
    check("fifo_cnt", fifo_cnt, sb.size());
    check("run_valid", run_valid, sb.size() != 0);
    check("busy", busy, m_busy);
    check("run_len", run_len, (sb.size() != 0) ? int'(sb[0]) : 0);
`ifdef RUN_MONITOR_OVF_EN
    check("ovf", ovf, m_ovf);
`endif
  endtask

  task automatic run(input int n);
    Y = 1'b1;
    repeat (n) step();
    Y = 1'b0;
    step();
  endtask

  task automatic drain();
    run_ready = 1'b1;
    Y = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (sb.size() == 0) break;
      step();
    end
    run_ready = 1'b0;
    check("drained_cnt", fifo_cnt, 0);
  endtask

  initial begin
    logic [7:0] exp_pops[5];
    vecs[0] = '{y:1'b0, ready:1'b1, valid:1'b0, len:8'd0, cnt:3'd0, bsy:1'b0};
    vecs[1] = '{y:1'b1, ready:1'b1, valid:1'b0, len:8'd0, cnt:3'd0, bsy:1'b1};
    vecs[2] = '{y:1'b1, ready:1'b1, valid:1'b0, len:8'd0, cnt:3'd0, bsy:1'b1};
    vecs[3] = '{y:1'b1, ready:1'b1, valid:1'b0, len:8'd0, cnt:3'd0, bsy:1'b1};
    vecs[4] = '{y:1'b0, ready:1'b1, valid:1'b1, len:8'd3, cnt:3'd1, bsy:1'b0};
    vecs[5] = '{y:1'b0, ready:1'b1, valid:1'b0, len:8'd0, cnt:3'd0, bsy:1'b0};
    vecs[6] = '{y:1'b0, ready:1'b1, valid:1'b0, len:8'd0, cnt:3'd0, bsy:1'b0};

    rst = 1'b0;
    Y = 1'b0;
    run_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_cnt", fifo_cnt, 0);
    check("rst_valid", run_valid, 0);
    check("rst_len", run_len, 0);
    check("rst_busy", busy, 0);
`ifdef RUN_MONITOR_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Pattern 0,1,1,1,0 with consumer always ready.
    foreach (vecs[i]) begin
      Y = vecs[i].y;
      run_ready = vecs[i].ready;
      step();
      check("tbl_valid", run_valid, vecs[i].valid);
      check("tbl_len", run_len, vecs[i].len);
      check("tbl_cnt", fifo_cnt, vecs[i].cnt);
      check("tbl_busy", busy, vecs[i].bsy);
    end
    run_ready = 1'b0;

    // Saturation: 300 highs.
    Y = 1'b1;
    repeat (300) step();
    Y = 1'b0;
    step();
    check("sat_len", run_len, 255);
    drain();

    // Fill with runs 1..5; the fifth is dropped.
    popped.delete();
    for (int l = 1; l <= 5; l++) run(l);
    check("full_cnt", fifo_cnt, 4);
`ifdef RUN_MONITOR_OVF_EN
    check("ovf_set", ovf, 1);
`endif
    // Full FIFO: run of 6 ends on the same edge as a pop.
    Y = 1'b1;
    repeat (6) step();
    Y = 1'b0;
    run_ready = 1'b1;
    step();
    run_ready = 1'b0;
    check("pushpop_cnt", fifo_cnt, 4);
    check("pushpop_npop", popped.size(), 1);
    drain();
    exp_pops = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd6};
    check("full_npops", popped.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < popped.size()) check("full_order", popped[i], exp_pops[i]);

    // Back-to-back single-cycle runs.
    popped.delete();
    Y = 1'b1; step();
    Y = 1'b0; step();
    Y = 1'b1; step();
    Y = 1'b0; step();
    check("b2b_cnt", fifo_cnt, 2);
    drain();
    check("b2b_npops", popped.size(), 2);
    for (int i = 0; i < 2; i++)
      if (i < popped.size()) check("b2b_val", popped[i], 1);

    // Reset mid-run with a stored entry present.
    run(2);
    Y = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    #1;
    sb.delete();
    m_busy = 1'b0;
    m_len  = 0;
    m_ovf  = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cnt", fifo_cnt, 0);
    check("mid_rst_valid", run_valid, 0);
    check("mid_rst_len", run_len, 0);
`ifdef RUN_MONITOR_OVF_EN
    check("mid_rst_ovf", ovf, 0);
`endif
    #2 rst = 1'b0;
    Y = 1'b0;
    step();
    step();
    check("post_rst_cnt", fifo_cnt, 0);
    check("post_rst_valid", run_valid, 0);
    Y = 1'b1;
    step();
    check("restart_busy", busy, 1);
    Y = 1'b0;
    step();
    check("restart_len", run_len, 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/run_monitor.md
RUN_MONITOR -- requirements
Module: run_monitor

Interface
REQ-001 SHALL have parameter: DEPTH, 4, number of run-length FIFO entries (power of two, at least 2).
REQ-002 SHALL have parameter: LEN_W, 8, run-length counter and FIFO data width.
REQ-003 SHALL have port: clk  input  1  single clock; all flops on the rising edge.
REQ-004 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: Y  input  1  serial detector output from the upstream sequence stage, sampled on each rising clk edge.
REQ-006 SHALL have port: run_len  output  LEN_W  length of the oldest unread high-run (FIFO head).
REQ-007 SHALL have port: run_valid  output  1  FIFO non-empty; run_len is valid.
REQ-008 SHALL have port: run_ready  input  1  consumer accepts the head entry.
REQ-009 SHALL have port: fifo_cnt  output  clog2(DEPTH)+1  number of stored entries.
REQ-010 SHALL have port: busy  output  1  high while a run is being measured (state RUN).

Function
REQ-011 SHALL implement a two-state FSM, IDLE and RUN, plus a LEN_W-bit run counter.
REQ-012 In IDLE, a sampled Y=1 SHALL load the counter with 1 and move the FSM to RUN; Y=0 SHALL keep it in IDLE.
REQ-013 In RUN, a sampled Y=1 SHALL increment the counter, saturating at 2^LEN_W-1 (no wrap).
REQ-014 In RUN, a sampled Y=0 SHALL push the counter value into the FIFO and return the FSM to IDLE on the same edge.
REQ-015 A run of N consecutive sampled highs SHALL produce exactly one entry equal to min(N, 2^LEN_W-1).
REQ-016 The FIFO SHALL be show-ahead: run_valid = (fifo_cnt != 0), and run_len = head entry, driven from registers.
REQ-017 A pushed entry SHALL make run_valid high in the cycle immediately after the push edge, giving a latency of one edge from the terminating Y=0 sample.
REQ-018 A pop SHALL occur on an edge where run_valid and run_ready are both high; run_len SHALL advance to the next entry after that edge.
REQ-019 run_ready while run_valid=0 SHALL have no effect.
REQ-020 Push while full without a simultaneous pop SHALL drop the new entry; stored entries and fifo_cnt SHALL remain unchanged.
REQ-021 Simultaneous push and pop SHALL both succeed, including when the FIFO is full, with fifo_cnt unchanged.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH.
REQ-023 run_len SHALL be 0 whenever run_valid=0.
REQ-024 busy SHALL be high exactly in state RUN.

Reset
REQ-025 Asserting rst SHALL immediately force: FSM to IDLE, counter to 0, FIFO pointers and fifo_cnt to 0, run_valid 0, run_len 0, and busy 0.
REQ-026 A reset asserted mid-run SHALL discard the partial run; no entry is pushed.
REQ-027 After rst deasserts, the first edge with Y=1 SHALL start a new run.

Configuration
REQ-028 With macro RUN_MONITOR_OVF_EN defined, the block SHALL add output ovf (1 bit), a sticky flag set on any dropped push (REQ-020) and cleared only by rst.
REQ-029 With RUN_MONITOR_OVF_EN undefined, the ovf port and its logic SHALL be absent, and drops SHALL be silent.

Verification
REQ-030 The bench SHALL cover: rst=1 mid-run with Y=1 for 3 cycles, then release -> fifo_cnt=0, run_valid=0, busy=0, and no entry produced.
REQ-031 The bench SHALL cover: Y pattern 0,1,1,1,0 with run_ready=1 -> run_valid high for one cycle after the Y=0 edge with run_len=3, then fifo_cnt returns to 0.
REQ-032 The bench SHALL cover: LEN_W=8, Y high for 300 cycles then 0 -> run_len=255 (saturated).
REQ-033 The bench SHALL cover: run_ready=0, five runs of lengths 1,2,3,4,5 -> fifo_cnt=4, entries read 1,2,3,4, the run of 5 dropped, and ovf=1 when RUN_MONITOR_OVF_EN is defined.
REQ-034 The bench SHALL cover: full FIFO, run_ready=1 on the same edge a run of 6 ends -> fifo_cnt stays 4, the oldest entry pops, and 6 is stored last.
REQ-035 The bench SHALL cover: back-to-back runs 1,0,1,0 -> two entries, both with value 1.
